// File: rtl/ptc_seq_pkg.sv
// ptc_seq_pkg: FSM encoding, PTC register map, host address map and small helpers
// shared by the PTC sequencer and its write port.
package ptc_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_W_HRC  = 3'd1,
    ST_W_LRC  = 3'd2,
    ST_W_CNTR = 3'd3,
    ST_W_CTRL = 3'd4,
    ST_RUN    = 3'd5,
    ST_W_STOP = 3'd6
  } state_e;

  localparam logic [1:0] PTC_CNTR = 2'd0;
  localparam logic [1:0] PTC_HRC  = 2'd1;
  localparam logic [1:0] PTC_LRC  = 2'd2;
  localparam logic [1:0] PTC_CTRL = 2'd3;

  localparam int unsigned PTC_CTRL_EN_BIT = 0;
  localparam int unsigned PTC_CTRL_OE_BIT = 3;
  localparam logic [31:0] PTC_CTRL_RUN =
    (32'd1 << PTC_CTRL_EN_BIT) | (32'd1 << PTC_CTRL_OE_BIT);

  localparam logic [2:0] CFG_CTRL   = 3'd4;
  localparam logic [2:0] CFG_STATUS = 3'd5;

  localparam int unsigned CTRL_START_BIT = 0;
  localparam int unsigned CTRL_STOP_BIT  = 1;
  localparam int unsigned CTRL_LOOP_BIT  = 2;

  // A repeat count of 0 behaves like 1 so every entry runs at least one period.
  function automatic logic [8:0] rep_target(input logic [7:0] rep);
    logic [8:0] tgt;
    tgt = (rep == 8'd0) ? 9'd1 : {1'b0, rep};
    return tgt;
  endfunction

  function automatic logic is_write_state(input state_e st);
    logic wr;
    case (st)
      ST_W_HRC, ST_W_LRC, ST_W_CNTR, ST_W_CTRL, ST_W_STOP: wr = 1'b1;
      default:                                             wr = 1'b0;
    endcase
    return wr;
  endfunction

  function automatic state_e next_write_state(input state_e st, input logic first);
    state_e nxt;
    case (st)
      ST_W_HRC:  nxt = ST_W_LRC;
      ST_W_LRC:  nxt = first ? ST_W_CNTR : ST_RUN;
      ST_W_CNTR: nxt = ST_W_CTRL;
      default:   nxt = ST_RUN;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/ptc_seq_wr_port.sv
// ptc_seq_wr_port: single-entry holding register for PTC register writes; the
// request stays up with stable address/data until the PTC acknowledges it.
module ptc_seq_wr_port
  import ptc_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [1:0]  load_addr,
  input  logic [31:0] load_data,
  input  logic        ptc_ack,
  output logic        ptc_wr,
  output logic [1:0]  ptc_addr,
  output logic [31:0] ptc_wdata,
  output logic        accept
);

  logic        wr_q, wr_d;
  logic [1:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;

  assign accept = wr_q & ptc_ack;

  // A new load may replace the write accepted in the same cycle (back-to-back writes).
  always_comb begin
    wr_d   = wr_q;
    addr_d = addr_q;
    data_d = data_q;
    if (load) begin
      wr_d   = 1'b1;
      addr_d = load_addr;
      data_d = load_data;
    end else if (accept) begin
      wr_d = 1'b0;
    end else begin
      wr_d = wr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q   <= 1'b0;
      addr_q <= PTC_CNTR;
      data_q <= 32'd0;
    end else begin
      wr_q   <= wr_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign ptc_wr    = wr_q;
  assign ptc_addr  = addr_q;
  assign ptc_wdata = data_q;

endmodule

// File: rtl/ptc_seq_ctrl.sv
// ptc_seq_ctrl: steps a PTC through a table of {LRC,HRC} entries, each held for rep periods.
// Build option: define PTC_SEQ_LOOP_EN to enable CTRL.loop wrap-around to entry 0.
module ptc_seq_ctrl
  import ptc_seq_pkg::*;
#(
  parameter int N_ENT = 4,
  parameter int CW    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic [31:0] cfg_rdata,
  output logic [1:0]  ptc_addr,
  output logic [31:0] ptc_wdata,
  output logic        ptc_wr,
  input  logic        ptc_ack,
  input  logic        ptc_period,
  output logic        busy,
  output logic        seq_irq,
  output logic [1:0]  cur_idx
);

`ifdef PTC_SEQ_LOOP_EN
  localparam logic LOOP_EN = 1'b1;
`else
  localparam logic LOOP_EN = 1'b0;
`endif

  localparam logic [15:0] CW_MASK  = 16'((32'd1 << CW) - 32'd1);
  localparam logic [1:0]  LAST_MAX = 2'(N_ENT - 1);

  state_e      state_q, state_d;
  logic [1:0]  cur_idx_q, cur_idx_d;
  logic [7:0]  rep_cnt_q, rep_cnt_d;
  logic        first_q, first_d;
  logic        stop_pend_q, stop_pend_d;
  logic        busy_q, busy_d;
  logic        seq_irq_q, seq_irq_d;
  logic [31:0] table_q [N_ENT];
  logic [31:0] table_d [N_ENT];
  logic        loop_q, loop_d;
  logic [1:0]  last_idx_q, last_idx_d;
  logic [7:0]  rep_q, rep_d;

  logic        ctrl_we_s, start_s, stop_s, accept_s, load_s;
  logic [1:0]  load_addr_s;
  logic [31:0] load_data_s, entry_s;
  logic [8:0]  rep_next_s;

  assign ctrl_we_s = cfg_we && (cfg_addr == CFG_CTRL);
  assign start_s   = ctrl_we_s && cfg_wdata[CTRL_START_BIT];
  assign stop_s    = ctrl_we_s && cfg_wdata[CTRL_STOP_BIT];

  // Host-visible configuration: table entries and the persistent CTRL fields.
  always_comb begin
    for (int i = 0; i < N_ENT; i++) begin
      table_d[i] = (cfg_we && (cfg_addr == 3'(i))) ? cfg_wdata : table_q[i];
    end
    if (ctrl_we_s) begin
      loop_d     = LOOP_EN & cfg_wdata[CTRL_LOOP_BIT];
      last_idx_d = (cfg_wdata[5:4] > LAST_MAX) ? LAST_MAX : cfg_wdata[5:4];
      rep_d      = cfg_wdata[15:8];
    end else begin
      loop_d     = loop_q;
      last_idx_d = last_idx_q;
      rep_d      = rep_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_idx_d   = cur_idx_q;
    rep_cnt_d   = rep_cnt_q;
    first_d     = first_q;
    stop_pend_d = stop_pend_q;
    seq_irq_d   = 1'b0;
    rep_next_s  = {1'b0, rep_cnt_q} + 9'd1;
    case (state_q)
      ST_IDLE: begin
        if (start_s && !stop_s) begin
          state_d     = ST_W_HRC;
          cur_idx_d   = 2'd0;
          rep_cnt_d   = 8'd0;
          first_d     = 1'b1;
          stop_pend_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_W_HRC, ST_W_LRC, ST_W_CNTR, ST_W_CTRL: begin
        // A stop seen during a write is remembered and honoured once the write lands.
        if (accept_s) begin
          stop_pend_d = 1'b0;
          first_d     = (state_q == ST_W_CTRL) ? 1'b0 : first_q;
          if (stop_s || stop_pend_q) begin
            state_d = ST_W_STOP;
          end else begin
            state_d = next_write_state(state_q, first_q);
          end
        end else begin
          stop_pend_d = stop_pend_q | stop_s;
        end
      end
      ST_RUN: begin
        if (stop_s) begin
          state_d = ST_W_STOP;
        end else if (ptc_period) begin
          if (rep_next_s >= rep_target(rep_q)) begin
            rep_cnt_d = 8'd0;
            if (cur_idx_q < last_idx_q) begin
              cur_idx_d = cur_idx_q + 2'd1;
              state_d   = ST_W_HRC;
            end else if (LOOP_EN && loop_q) begin
              cur_idx_d = 2'd0;
              state_d   = ST_W_HRC;
            end else begin
              state_d = ST_W_STOP;
            end
          end else begin
            rep_cnt_d = rep_next_s[7:0];
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_W_STOP: begin
        if (accept_s) begin
          state_d   = ST_IDLE;
          seq_irq_d = 1'b1;
        end else begin
          state_d = ST_W_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Every entry into a write state presents exactly one new PTC write.
  always_comb begin
    entry_s = 32'd0;
    for (int i = 0; i < N_ENT; i++) begin
      entry_s = (cur_idx_d == 2'(i)) ? table_q[i] : entry_s;
    end
    load_s = (state_d != state_q) && is_write_state(state_d);
    case (state_d)
      ST_W_HRC: begin
        load_addr_s = PTC_HRC;
        load_data_s = {16'd0, entry_s[15:0] & CW_MASK};
      end
      ST_W_LRC: begin
        load_addr_s = PTC_LRC;
        load_data_s = {16'd0, entry_s[31:16] & CW_MASK};
      end
      ST_W_CTRL: begin
        load_addr_s = PTC_CTRL;
        load_data_s = PTC_CTRL_RUN;
      end
      ST_W_STOP: begin
        load_addr_s = PTC_CTRL;
        load_data_s = 32'd0;
      end
      default: begin
        load_addr_s = PTC_CNTR;
        load_data_s = 32'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cur_idx_q   <= 2'd0;
      rep_cnt_q   <= 8'd0;
      first_q     <= 1'b0;
      stop_pend_q <= 1'b0;
      busy_q      <= 1'b0;
      seq_irq_q   <= 1'b0;
      loop_q      <= 1'b0;
      last_idx_q  <= 2'd0;
      rep_q       <= 8'd0;
      for (int i = 0; i < N_ENT; i++) begin
        table_q[i] <= 32'd0;
      end
    end else begin
      state_q     <= state_d;
      cur_idx_q   <= cur_idx_d;
      rep_cnt_q   <= rep_cnt_d;
      first_q     <= first_d;
      stop_pend_q <= stop_pend_d;
      busy_q      <= busy_d;
      seq_irq_q   <= seq_irq_d;
      loop_q      <= loop_d;
      last_idx_q  <= last_idx_d;
      rep_q       <= rep_d;
      table_q     <= table_d;
    end
  end

  always_comb begin
    cfg_rdata = 32'd0;
    case (cfg_addr)
      CFG_CTRL:   cfg_rdata = {16'd0, rep_q, 2'b00, last_idx_q, 1'b0, loop_q, 2'b00};
      CFG_STATUS: cfg_rdata = {16'd0, rep_cnt_q, 2'b00, cur_idx_q, 1'b0, state_q};
      default: begin
        for (int i = 0; i < N_ENT; i++) begin
          cfg_rdata = (cfg_addr == 3'(i)) ? table_q[i] : cfg_rdata;
        end
      end
    endcase
  end

  ptc_seq_wr_port u_wr_port (
    .clk       (clk),
    .rst       (rst),
    .load      (load_s),
    .load_addr (load_addr_s),
    .load_data (load_data_s),
    .ptc_ack   (ptc_ack),
    .ptc_wr    (ptc_wr),
    .ptc_addr  (ptc_addr),
    .ptc_wdata (ptc_wdata),
    .accept    (accept_s)
  );

  assign busy    = busy_q;
  assign seq_irq = seq_irq_q;
  assign cur_idx = cur_idx_q;

endmodule

// File: doc/ptc_seq_ctrl.md
PTC_SEQ_CTRL -- requirements
Module: ptc_seq_ctrl

Interface
REQ-001 SHALL have parameter N_ENT, default 4, meaning number of table entries (2..4).
REQ-002 SHALL have parameter CW, default 16, meaning counter width of the PTC being driven (8..16).
REQ-003 SHALL have port clk, input, 1, the single clock; all state is clocked on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port cfg_we, input, 1, host write strobe.
REQ-006 SHALL have port cfg_addr, input, 3, host address: 0..N_ENT-1 select table entries, 4 selects CTRL, 5 selects STATUS.
REQ-007 SHALL have port cfg_wdata, input, 32, host write data.
REQ-008 SHALL have port cfg_rdata, output, 32, combinational read of the addressed word; unmapped addresses read 0.
REQ-009 SHALL have port ptc_addr, output, 2, PTC register select: 0 CNTR, 1 HRC, 2 LRC, 3 CTRL.
REQ-010 SHALL have port ptc_wdata, output, 32, PTC write data.
REQ-011 SHALL have port ptc_wr, output, 1, PTC write request.
REQ-012 SHALL have port ptc_ack, input, 1, PTC write accepted.
REQ-013 SHALL have port ptc_period, input, 1, one-cycle pulse at each PTC LRC match (period end).
REQ-014 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-015 SHALL have port seq_irq, output, 1, one-cycle pulse on sequence completion.
REQ-016 SHALL have port cur_idx, output, 2, index of the active table entry.

Function
REQ-017 Each table entry SHALL be {lrc[31:16], hrc[15:0]}; only the low CW bits of each half are forwarded to the PTC, and upper bits are written as 0.
REQ-018 CTRL SHALL be laid out as: [0] start (self-clearing), [1] stop (self-clearing), [2] loop, [5:4] last_idx, [15:8] rep; last_idx is saturated to N_ENT-1.
REQ-019 STATUS SHALL read {rep_cnt[15:8], cur_idx[5:4], fsm_state[2:0]}.
REQ-020 The FSM states SHALL be IDLE, W_HRC, W_LRC, W_CNTR, W_CTRL, RUN and W_STOP.
REQ-021 On start in IDLE: cur_idx=0, rep_cnt=0, first=1, and the next state is W_HRC.
REQ-022 The write sequence SHALL be W_HRC -> W_LRC -> (first ? W_CNTR : RUN).
REQ-023 After W_LRC, the sequence SHALL continue W_CNTR (data 0) -> W_CTRL (data 0x009, EN|OE) -> RUN, and first SHALL clear.
REQ-024 Handshake: in each W_* state, ptc_wr=1 with ptc_addr/ptc_wdata stable until the cycle ptc_ack=1; the state advances on that edge.
REQ-025 Exactly one write SHALL be in flight at a time, with no combinational path from ptc_ack to ptc_wr.
REQ-026 In RUN, each ptc_period pulse SHALL increment rep_cnt.
REQ-027 In RUN, when rep_cnt+1 reaches max(rep,1), rep_cnt SHALL clear and the block SHALL advance.
REQ-028 Advance: if cur_idx<last_idx, increment cur_idx and go to W_HRC.
REQ-029 Advance: else if loop=1, set cur_idx=0 and go to W_HRC.
REQ-030 Advance: else go to W_STOP.
REQ-031 ptc_period pulses outside RUN SHALL be ignored.
REQ-032 W_STOP SHALL write CTRL=0; on ack the block goes to IDLE and pulses seq_irq for one cycle.
REQ-033 stop in RUN SHALL go to W_STOP; stop in a W_* state SHALL complete the pending write, then go to W_STOP.
REQ-034 start while busy SHALL be ignored.
REQ-035 If start and stop are written in the same cycle, stop SHALL win.
REQ-036 Host writes to table entries SHALL be allowed at any time; an entry is sampled when its W_HRC/W_LRC write is presented.
REQ-037 A host write to CTRL while busy SHALL update loop, last_idx and rep only.

Reset
REQ-038 rst SHALL force state IDLE, table=0, CTRL=0, rep_cnt=0, cur_idx=0, first=0.
REQ-039 rst SHALL force ptc_wr=0, ptc_addr=0, ptc_wdata=0, busy=0 and seq_irq=0.
REQ-040 rst asserted mid-write SHALL drop ptc_wr in the next cycle; the PTC is not stopped by this block.

Configuration
REQ-041 Macro PTC_SEQ_LOOP_EN: when defined, CTRL[2] loop behaves as in REQ-029.
REQ-042 When PTC_SEQ_LOOP_EN is undefined, CTRL[2] SHALL read 0, ignore writes, and reaching last_idx always goes to W_STOP.

Structure
REQ-043 A shared package ptc_seq_pkg SHALL hold the FSM state enum, PTC register indices (CNTR=0, HRC=1, LRC=2, CTRL=3), CTRL bit positions (EN=0, OE=3) and the CFG address constants.
REQ-044 One sub-module ptc_seq_wr_port SHALL hold the request/ack write holding register and flag; the FSM and table stay in ptc_seq_ctrl.

Verification
REQ-045 Scenario: entry0=0x0040_0010, rep=1, last_idx=0, start, ack on the first request cycle -> writes HRC=0x10, LRC=0x40, CNTR=0, CTRL=0x009 in order; busy=1.
REQ-046 Scenario: continuing REQ-045, one ptc_period pulse -> CTRL=0 written, then seq_irq for 1 cycle, then IDLE.
REQ-047 Scenario: 3 entries, rep=2, loop=0 -> each entry is loaded after 2 pulses, cur_idx steps 0,1,2, and CNTR/CTRL are written only once at start.
REQ-048 Scenario: loop=1, last_idx=1 -> after entry1's repeats, cur_idx=0 and HRC/LRC are rewritten; with PTC_SEQ_LOOP_EN undefined -> W_STOP instead.
REQ-049 Scenario: ptc_ack held low for 5 cycles in W_LRC -> ptc_wr/addr/data stable for 5 cycles, and pulses in that window do not change rep_cnt.
REQ-050 Scenario: stop during W_HRC -> the HRC write completes, CTRL=0 is written, seq_irq pulses; a further start while busy has no effect.
